hdlc_destuff_fcs: RTL
=====================

// Module: hdlc_destuff_fcs
// PURPOSE
//  Sits directly downstream of the flag-delineation stage in the HDLC deframer.
//  Removes 0x7D byte stuffing, runs CRC-16/X.25 over each destuffed frame,
//  strips the 2 FCS bytes and emits the payload with sop/eop plus per-frame
//  status (FCS error, abort, runt drop).
// PARAMETERS
//  MAX_BYTES  1504  max payload bytes per frame; beyond this the frame is aborted
// PORTS
//  clk          in   1  clock, all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  in_valid     in   1  in_data/in_sop/in_eop qualified this cycle
//  in_sop       in   1  first byte of frame (payload byte, not a flag)
//  in_eop       in   1  closing-flag cycle; in_data==8'h7E, not part of frame
//  in_data      in   8  stuffed frame byte
//  out_valid    out  1  out_* qualified
//  out_sop      out  1  first payload byte
//  out_eop      out  1  frame end; status outputs valid only on this cycle
//  out_data     out  8  destuffed payload byte
//  out_fcs_err  out  1  with out_eop: CRC residue != 16'hF0B8
//  out_abort    out  1  with out_eop: frame aborted (escape+flag, restart, oversize)
//  drop_runt    out  1  1-cycle pulse: frame ended with <3 destuffed bytes, nothing emitted
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, buffer/count cleared, crc=16'hFFFF.
//  - States: IDLE, DATA, ESC, DISCARD. in_valid=0 cycles change nothing.
//  - IDLE: in_sop -> init crc, process byte, DATA. Non-sop bytes ignored.
//  - DATA: 8'h7D -> ESC, byte dropped; other byte -> destuffed byte = in_data.
//  - ESC: next byte -> destuffed byte = in_data ^ 8'h20, back to DATA.
//  - Each destuffed byte: crc updated (reflected poly 16'h8408, LSB first),
//    pushed into 3-deep delay buffer, count++ (saturating).
//  - Push with buffer full: oldest byte emitted, out_valid=1 next cycle;
//    out_sop=1 on first emitted byte of frame. Latency: a byte appears 1 cycle
//    after the in_valid cycle that pushes it out (3 destuffed bytes later).
//  - in_eop in DATA, count>=3: buffer[oldest] emitted with out_eop=1
//    (out_sop=1 too if count==3); the 2 newer bytes (FCS) discarded;
//    out_fcs_err=(crc!=16'hF0B8); out_abort=0; -> IDLE.
//  - in_eop in DATA, count<3: no output, drop_runt=1; -> IDLE.
//  - in_eop in ESC (escape then flag): abort; -> IDLE.
//  - in_sop in DATA/ESC (frame restarted, no flag): abort old frame, then same
//    cycle start new frame (buffer cleared, crc init, byte processed).
//  - Destuffed count reaches MAX_BYTES+3: abort; -> DISCARD. DISCARD ignores
//    all bytes until in_eop (-> IDLE) or in_sop (new frame, no 2nd abort).
//  - Abort: if >=1 byte already emitted: one terminator cycle out_valid=1,
//    out_eop=1, out_abort=1, out_fcs_err=0, out_data=8'h00. Else no output,
//    drop_runt=1. Buffered bytes discarded.
//  - Outputs registered; out_sop/out_eop/out_fcs_err/out_abort/drop_runt are
//    single-cycle, 0 whenever out_valid=0 (drop_runt excepted).
//  - rst mid-frame: frame lost silently, no eop emitted; sop required afterwards.
// STRUCTURE
//  - hdlc_pkg: HDLC_FLAG=8'h7E, HDLC_ESC=8'h7D, HDLC_XOR=8'h20,
//    FCS_INIT=16'hFFFF, FCS_POLY=16'h8408, FCS_GOOD=16'hF0B8, state typedef.
//  - Sub-module hdlc_fcs16: combinational byte-wide crc_next(crc, byte).
//  - Top: FSM, 3-byte delay buffer, byte counter, output registers.
// TESTING
//  - "123456789" (31..39), 6E 90, flag -> 9 bytes 31..39, sop on 31,
//    eop on 39, out_fcs_err=0, out_abort=0.
//  - Same frame with 90 changed to 91 -> same 9 bytes, out_fcs_err=1.
//  - Payload 31 7D 5E 32 7D 5D + valid FCS -> out 31 7E 32 7D, eop on 7D, err=0.
//  - 31 32 33 34 7D flag -> 31 emitted, then terminator 00 eop abort=1.
//  - 31 32 flag -> no out_valid, drop_runt pulses once; 31 then sop 41... ->
//    drop_runt, new frame decoded normally.
//  - MAX_BYTES=4, 10-byte frame -> 4 bytes out then abort terminator, rest
//    ignored; rst mid-frame -> all outputs 0 next cycle, next sop frame ok.

Source files
------------

// File: rtl/hdlc_pkg.sv
// Shared constants and state encoding for the HDLC destuff/FCS stage.
package hdlc_pkg;

    localparam logic [7:0]  HDLC_FLAG = 8'h7E;
    localparam logic [7:0]  HDLC_ESC  = 8'h7D;
    localparam logic [7:0]  HDLC_XOR  = 8'h20;

    localparam logic [15:0] FCS_INIT  = 16'hFFFF;
    localparam logic [15:0] FCS_POLY  = 16'h8408;
    localparam logic [15:0] FCS_GOOD  = 16'hF0B8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ESC,
        ST_DISCARD
    } hdlc_state_t;

endpackage

// File: rtl/hdlc_fcs16.sv
// Combinational byte-wide CRC-16/X.25 step, reflected polynomial, LSB first.
module hdlc_fcs16
    import hdlc_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_acc;

    always_comb begin
        w_acc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[0] ^ i_data[i]) begin
                w_acc = (w_acc >> 1) ^ FCS_POLY;
            end else begin
                w_acc = w_acc >> 1;
            end
        end
    end

    assign o_crc = w_acc;

endmodule

// File: rtl/hdlc_destuff_fcs.sv
// Removes 0x7D byte stuffing, checks CRC-16/X.25 and strips the FCS, emitting
// the payload with sop/eop and per-frame status (FCS error, abort, runt drop).
module hdlc_destuff_fcs
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 1504
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sop,
    input  logic       in_eop,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic [7:0] out_data,
    output logic       out_fcs_err,
    output logic       out_abort,
    output logic       drop_runt
);

    localparam int CNT_MAX = MAX_BYTES + 3;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_FULL = CW'(3);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    hdlc_state_t   r_state, w_stateNext;
    logic [15:0]   r_crc, w_crcNext, w_crcIn, w_crcUpd;
    logic [7:0]    r_buf [3];
    logic [7:0]    w_bufNext [3];
    logic [CW-1:0] r_count, w_countNext;
    logic          r_emitted, w_emittedNext;
    logic          r_pendAbort, w_pendNext;
    logic          w_newFrame, w_push;
    logic [7:0]    w_byte, w_crcByte;

    logic          r_outValid, r_outSop, r_outEop, r_outErr, r_outAbort, r_outRunt;
    logic [7:0]    r_outData;
    logic          w_outValid, w_outSop, w_outEop, w_outErr, w_outAbort, w_outRunt;
    logic [7:0]    w_outData;

    // A sop always opens a fresh frame; the escape xor never applies to it.
    assign w_newFrame = in_valid && in_sop && !in_eop;
    assign w_byte     = (r_state == ST_ESC) ? (in_data ^ HDLC_XOR) : in_data;
    assign w_crcIn    = w_newFrame ? FCS_INIT : r_crc;
    assign w_crcByte  = w_newFrame ? in_data : w_byte;

    hdlc_fcs16 u_fcs16 (
        .i_crc  (w_crcIn),
        .i_data (w_crcByte),
        .o_crc  (w_crcUpd)
    );

    always_comb begin
        w_stateNext   = r_state;
        w_crcNext     = r_crc;
        w_bufNext     = r_buf;
        w_countNext   = r_count;
        w_emittedNext = r_emitted;
        w_pendNext    = 1'b0;
        w_push        = 1'b0;
        w_outValid    = 1'b0;
        w_outSop      = 1'b0;
        w_outEop      = 1'b0;
        w_outData     = 8'h00;
        w_outErr      = 1'b0;
        w_outAbort    = 1'b0;
        w_outRunt     = 1'b0;

        // Oversize terminator is deferred one cycle so the last good byte gets out first.
        if (r_pendAbort) begin
            w_outValid = 1'b1;
            w_outEop   = 1'b1;
            w_outAbort = 1'b1;
        end

        if (in_valid) begin
            if (w_newFrame) begin
                if (r_state == ST_DATA || r_state == ST_ESC) begin
                    if (r_emitted) begin
                        w_outValid = 1'b1;
                        w_outEop   = 1'b1;
                        w_outAbort = 1'b1;
                    end else begin
                        w_outRunt  = 1'b1;
                    end
                end
                w_bufNext     = '{default: 8'h00};
                w_emittedNext = 1'b0;
                w_countNext   = '0;
                w_crcNext     = FCS_INIT;
                if (in_data == HDLC_ESC) begin
                    w_stateNext = ST_ESC;
                end else begin
                    w_crcNext    = w_crcUpd;
                    w_bufNext[0] = in_data;
                    w_countNext  = CNT_ONE;
                    w_stateNext  = ST_DATA;
                end
            end else begin
                case (r_state)
                    ST_DATA: begin
                        if (in_eop) begin
                            w_stateNext = ST_IDLE;
                            if (r_count >= CNT_FULL) begin
                                w_outValid = 1'b1;
                                w_outData  = r_buf[2];
                                w_outSop   = !r_emitted;
                                w_outEop   = 1'b1;
                                w_outErr   = (r_crc != FCS_GOOD);
                            end else begin
                                w_outRunt  = 1'b1;
                            end
                        end else if (in_data == HDLC_ESC) begin
                            w_stateNext = ST_ESC;
                        end else begin
                            w_push = 1'b1;
                        end
                    end
                    ST_ESC: begin
                        if (in_eop) begin
                            w_stateNext = ST_IDLE;
                            if (r_emitted) begin
                                w_outValid = 1'b1;
                                w_outEop   = 1'b1;
                                w_outAbort = 1'b1;
                            end else begin
                                w_outRunt  = 1'b1;
                            end
                        end else begin
                            w_push      = 1'b1;
                            w_stateNext = ST_DATA;
                        end
                    end
                    ST_DISCARD: begin
                        if (in_eop) begin
                            w_stateNext = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        // The delay buffer holds back the two newest bytes so the FCS never leaves.
        if (w_push) begin
            w_crcNext    = w_crcUpd;
            w_bufNext[0] = w_byte;
            w_bufNext[1] = r_buf[0];
            w_bufNext[2] = r_buf[1];
            if (r_count >= CNT_FULL) begin
                w_outValid    = 1'b1;
                w_outData     = r_buf[2];
                w_outSop      = !r_emitted;
                w_emittedNext = 1'b1;
            end
            if (r_count != CNT_TOP) begin
                w_countNext = r_count + CNT_ONE;
            end
            if (w_countNext == CNT_TOP) begin
                w_stateNext = ST_DISCARD;
                if (w_emittedNext) begin
                    w_pendNext = 1'b1;
                end else begin
                    w_outRunt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_crc       <= FCS_INIT;
            r_buf       <= '{default: 8'h00};
            r_count     <= '0;
            r_emitted   <= 1'b0;
            r_pendAbort <= 1'b0;
            r_outValid  <= 1'b0;
            r_outSop    <= 1'b0;
            r_outEop    <= 1'b0;
            r_outData   <= 8'h00;
            r_outErr    <= 1'b0;
            r_outAbort  <= 1'b0;
            r_outRunt   <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_crc       <= w_crcNext;
            r_buf       <= w_bufNext;
            r_count     <= w_countNext;
            r_emitted   <= w_emittedNext;
            r_pendAbort <= w_pendNext;
            r_outValid  <= w_outValid;
            r_outSop    <= w_outSop;
            r_outEop    <= w_outEop;
            r_outData   <= w_outData;
            r_outErr    <= w_outErr;
            r_outAbort  <= w_outAbort;
            r_outRunt   <= w_outRunt;
        end
    end

    assign out_valid   = r_outValid;
    assign out_sop     = r_outSop;
    assign out_eop     = r_outEop;
    assign out_data    = r_outData;
    assign out_fcs_err = r_outErr;
    assign out_abort   = r_outAbort;
    assign drop_runt   = r_outRunt;

endmodule
